// File: rtl/gmii_rx_framer_pkg.sv
// Shared constants and types for the GMII receive framer and its CRC helper.
package eth_rx_pkg;

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
   localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // Ethernet shifts LSB first, so the datapath uses the bit-reversed polynomial.
   localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/gmii_rx_framer_if.sv
// GMII receive byte stream in, framed payload stream out.
interface gmii_rx_framer_if;
   logic       gmii_rx_en;
   logic       gmii_rx_er;
   logic [7:0] gmii_rx_data;
   logic       rx_frame_start;
   logic       rx_frame_data_valid;
   logic [7:0] rx_frame_data;
   logic       rx_frame_commit;
   logic       rx_frame_drop;

   modport master (output gmii_rx_en, gmii_rx_er, gmii_rx_data,
                   input  rx_frame_start, rx_frame_data_valid, rx_frame_data,
                          rx_frame_commit, rx_frame_drop);
   modport slave  (input  gmii_rx_en, gmii_rx_er, gmii_rx_data,
                   output rx_frame_start, rx_frame_data_valid, rx_frame_data,
                          rx_frame_commit, rx_frame_drop);
endinterface

// File: rtl/crc32_eth_byte.sv
// One-byte step of the reflected Ethernet CRC-32; no init or final XOR applied here.
module crc32_eth_byte
   import eth_rx_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);
   logic [31:0] c;

   always_comb begin
      c = crc_i ^ {24'h0, data_i};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      crc_o = c;
   end
endmodule

// File: rtl/gmii_rx_framer.sv
// Strips preamble/SFD and FCS from GMII receive frames, checks CRC and length,
// and emits payload with start/commit/drop framing plus saturating counters.
module gmii_rx_framer
   import eth_rx_pkg::*;
#(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             link_up,
   gmii_rx_framer_if.slave  bus,
   output logic [15:0]      frames_ok,
   output logic [15:0]      frames_crc_err,
   output logic [15:0]      frames_len_err
);
   localparam logic [10:0] LEN_MIN = 11'(MIN_FRAME);
   localparam logic [10:0] LEN_SAT = 11'(MAX_FRAME + 1);

   rx_state_t       state_q;
   logic            en_prev_q;
   logic [31:0]     crc_q, crc_d;
   logic [10:0]     len_q, len_d;
   logic [3:0][7:0] pipe_q;
   logic [2:0]      fill_q;
   logic            started_q;
   logic            pend_commit_q, pend_drop_q;
   logic            start_q, dv_q, commit_q, drop_q;
   logic [7:0]      data_q;
   logic [15:0]     ok_q, crc_err_q, len_err_q;

   crc32_eth_byte u_crc (.crc_i(crc_q), .data_i(bus.gmii_rx_data), .crc_o(crc_d));

   assign len_d = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;

   // Results are staged through pend_* so a gap cycle always separates the
   // last payload byte from commit/drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         en_prev_q     <= 1'b1;
         crc_q         <= CRC_INIT;
         len_q         <= '0;
         pipe_q        <= '0;
         fill_q        <= '0;
         started_q     <= 1'b0;
         pend_commit_q <= 1'b0;
         pend_drop_q   <= 1'b0;
         start_q       <= 1'b0;
         dv_q          <= 1'b0;
         commit_q      <= 1'b0;
         drop_q        <= 1'b0;
         data_q        <= '0;
         ok_q          <= '0;
         crc_err_q     <= '0;
         len_err_q     <= '0;
      end else begin
         en_prev_q     <= bus.gmii_rx_en;
         start_q       <= 1'b0;
         dv_q          <= 1'b0;
         commit_q      <= pend_commit_q;
         drop_q        <= pend_drop_q;
         pend_commit_q <= 1'b0;
         pend_drop_q   <= 1'b0;
         if (!link_up) begin
            if (state_q == DATA) pend_drop_q <= started_q;
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: if (bus.gmii_rx_en && !en_prev_q) state_q <= PREAMBLE;
               PREAMBLE: begin
                  if (bus.gmii_rx_en && !bus.gmii_rx_er && bus.gmii_rx_data == SFD_BYTE) begin
                     state_q   <= DATA;
                     crc_q     <= CRC_INIT;
                     len_q     <= '0;
                     fill_q    <= '0;
                     started_q <= 1'b0;
                  end else if (!bus.gmii_rx_en || bus.gmii_rx_er ||
                               bus.gmii_rx_data != PREAMBLE_BYTE) begin
                     state_q <= IDLE;
                  end
               end
               DATA: begin
                  if (!bus.gmii_rx_en) begin
                     state_q <= IDLE;
                     if (len_q < LEN_MIN) begin
                        len_err_q   <= sat_inc16(len_err_q);
                        pend_drop_q <= started_q;
                     end else if (crc_q != CRC_RESIDUE) begin
                        crc_err_q   <= sat_inc16(crc_err_q);
                        pend_drop_q <= started_q;
                     end else begin
                        ok_q          <= sat_inc16(ok_q);
                        pend_commit_q <= started_q;
                     end
                  end else if (bus.gmii_rx_er) begin
                     state_q     <= DROP;
                     pend_drop_q <= started_q;
                  end else if (len_d == LEN_SAT) begin
                     state_q     <= DROP;
                     len_q       <= len_d;
                     len_err_q   <= sat_inc16(len_err_q);
                     pend_drop_q <= started_q;
                  end else begin
                     crc_q  <= crc_d;
                     len_q  <= len_d;
                     pipe_q <= {pipe_q[2:0], bus.gmii_rx_data};
                     // The newest four bytes are held back so the FCS is never emitted.
                     if (fill_q == 3'd4) begin
                        data_q    <= pipe_q[3];
                        dv_q      <= 1'b1;
                        start_q   <= !started_q;
                        started_q <= 1'b1;
                     end else begin
                        fill_q <= fill_q + 3'd1;
                     end
                  end
               end
               DROP: if (!bus.gmii_rx_en) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.rx_frame_start      = start_q;
   assign bus.rx_frame_data_valid = dv_q;
   assign bus.rx_frame_data       = data_q;
   assign bus.rx_frame_commit     = commit_q;
   assign bus.rx_frame_drop       = drop_q;
   assign frames_ok               = ok_q;
   assign frames_crc_err          = crc_err_q;
   assign frames_len_err          = len_err_q;
endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: good, CRC, runt, oversize, error, link and reset cases.
module tb_gmii_rx_framer;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic link_up = 1'b1;
   logic [15:0] frames_ok, frames_crc_err, frames_len_err;
   int n_chk = 0;
   int n_fail = 0;

   int cyc, start_cnt, start_bad, commit_cnt, drop_cnt, overlap, last_dv_cyc, commit_cyc, drop_cyc;
   bq_t rx_q;
   bq_t PRE;

   gmii_rx_framer_if bus();

   gmii_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
      .clk(clk), .rst(rst), .link_up(link_up), .bus(bus),
      .frames_ok(frames_ok), .frames_crc_err(frames_crc_err), .frames_len_err(frames_len_err));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (bus.rx_frame_start) begin
         start_cnt++;
         if (!(bus.rx_frame_data_valid && rx_q.size() == 0)) start_bad++;
      end
      if (bus.rx_frame_data_valid) begin
         rx_q.push_back(bus.rx_frame_data);
         last_dv_cyc = cyc;
      end
      if (bus.rx_frame_commit) begin commit_cnt++; commit_cyc = cyc; end
      if (bus.rx_frame_drop) begin drop_cnt++; drop_cyc = cyc; end
      if ((bus.rx_frame_commit || bus.rx_frame_drop) && bus.rx_frame_data_valid) overlap++;
   end

   function automatic bq_t make_payload(input int n, input int seed);
      bq_t p;
      for (int i = 0; i < n; i++) p.push_back(8'((i * 7 + seed * 13 + 1) & 255));
      return p;
   endfunction

   function automatic bq_t with_fcs(input bq_t p);
      logic [31:0] c;
      bq_t r;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < p.size(); i++) begin
         c = c ^ {24'h0, p[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      r = p;
      r.push_back(c[7:0]); r.push_back(c[15:8]); r.push_back(c[23:16]); r.push_back(c[31:24]);
      return r;
   endfunction

   task automatic clear_mon();
      @(posedge clk);
      rx_q.delete();
      start_cnt = 0; start_bad = 0; commit_cnt = 0; drop_cnt = 0; overlap = 0;
      last_dv_cyc = 0; commit_cyc = 0; drop_cyc = 0;
   endtask

   task automatic drive_frame(input bq_t pre, input bq_t body, input int er_idx, input int lnk_idx);
      for (int i = 0; i < pre.size(); i++) begin
         @(negedge clk);
         bus.gmii_rx_en = 1'b1; bus.gmii_rx_er = 1'b0; bus.gmii_rx_data = pre[i];
      end
      for (int i = 0; i < body.size(); i++) begin
         @(negedge clk);
         bus.gmii_rx_en = 1'b1; bus.gmii_rx_er = (i == er_idx); bus.gmii_rx_data = body[i];
         link_up = (i != lnk_idx);
      end
      @(negedge clk);
      bus.gmii_rx_en = 1'b0; bus.gmii_rx_er = 1'b0; bus.gmii_rx_data = 8'h00; link_up = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_chk++; if (bus.rx_frame_data_valid !== 1'b0 || bus.rx_frame_start !== 1'b0) begin
         n_fail++; $display("FAIL reset_dv_start: got dv=%b start=%b required 0", bus.rx_frame_data_valid, bus.rx_frame_start); end
      n_chk++; if (bus.rx_frame_commit !== 1'b0 || bus.rx_frame_drop !== 1'b0) begin
         n_fail++; $display("FAIL reset_commit_drop: got %b/%b required 0", bus.rx_frame_commit, bus.rx_frame_drop); end
      n_chk++; if ({frames_ok, frames_crc_err, frames_len_err} !== 48'h0) begin
         n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d required 0", frames_ok, frames_crc_err, frames_len_err); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good();
      bq_t p = make_payload(60, 1);
      int bad = 0;
      clear_mon();
      drive_frame(PRE, with_fcs(p), -1, -1);
      for (int i = 0; i < rx_q.size() && i < 60; i++) if (rx_q[i] !== p[i]) bad++;
      n_chk++; if (rx_q.size() != 60) begin n_fail++; $display("FAIL good_len: got %0d required 60", rx_q.size()); end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL good_bytes: got %0d wrong bytes required 0", bad); end
      n_chk++; if (start_cnt != 1 || start_bad != 0) begin n_fail++; $display("FAIL good_start: got %0d starts, %0d misplaced required 1/0", start_cnt, start_bad); end
      n_chk++; if (commit_cnt != 1 || drop_cnt != 0) begin n_fail++; $display("FAIL good_commit: got commit=%0d drop=%0d required 1/0", commit_cnt, drop_cnt); end
      n_chk++; if (commit_cyc - last_dv_cyc != 2) begin n_fail++; $display("FAIL good_commit_gap: got %0d required 2", commit_cyc - last_dv_cyc); end
      n_chk++; if (frames_ok !== 16'd1 || overlap != 0) begin n_fail++; $display("FAIL good_count: got ok=%0d overlap=%0d required 1/0", frames_ok, overlap); end
   endtask

   task automatic test_crc_err();
      bq_t f = with_fcs(make_payload(60, 2));
      f[10] = f[10] ^ 8'h04;
      clear_mon();
      drive_frame(PRE, f, -1, -1);
      n_chk++; if (rx_q.size() != 60) begin n_fail++; $display("FAIL crc_len: got %0d required 60", rx_q.size()); end
      n_chk++; if (drop_cnt != 1 || commit_cnt != 0) begin n_fail++; $display("FAIL crc_drop: got drop=%0d commit=%0d required 1/0", drop_cnt, commit_cnt); end
      n_chk++; if (drop_cyc - last_dv_cyc != 2) begin n_fail++; $display("FAIL crc_drop_gap: got %0d required 2", drop_cyc - last_dv_cyc); end
      n_chk++; if (frames_crc_err !== 16'd1 || frames_ok !== 16'd1) begin n_fail++; $display("FAIL crc_count: got crc=%0d ok=%0d required 1/1", frames_crc_err, frames_ok); end
   endtask

   task automatic test_runt();
      bq_t tiny = make_payload(3, 3);
      clear_mon();
      drive_frame(PRE, with_fcs(make_payload(36, 4)), -1, -1);
      n_chk++; if (rx_q.size() != 36 || drop_cnt != 1 || commit_cnt != 0) begin
         n_fail++; $display("FAIL runt40: got bytes=%0d drop=%0d commit=%0d required 36/1/0", rx_q.size(), drop_cnt, commit_cnt); end
      n_chk++; if (frames_len_err !== 16'd1) begin n_fail++; $display("FAIL runt40_count: got %0d required 1", frames_len_err); end
      clear_mon();
      drive_frame(PRE, tiny, -1, -1);
      n_chk++; if (rx_q.size() != 0 || start_cnt != 0 || drop_cnt != 0 || commit_cnt != 0) begin
         n_fail++; $display("FAIL runt3: got bytes=%0d start=%0d drop=%0d commit=%0d required 0", rx_q.size(), start_cnt, drop_cnt, commit_cnt); end
      n_chk++; if (frames_len_err !== 16'd2) begin n_fail++; $display("FAIL runt3_count: got %0d required 2", frames_len_err); end
   endtask

   task automatic test_oversize();
      clear_mon();
      drive_frame(PRE, make_payload(1600, 5), -1, -1);
      n_chk++; if (rx_q.size() != 1514) begin n_fail++; $display("FAIL over_bytes: got %0d required 1514", rx_q.size()); end
      n_chk++; if (drop_cnt != 1 || commit_cnt != 0 || drop_cyc <= last_dv_cyc) begin
         n_fail++; $display("FAIL over_drop: got drop=%0d commit=%0d dropcyc=%0d lastdv=%0d", drop_cnt, commit_cnt, drop_cyc, last_dv_cyc); end
      n_chk++; if (frames_len_err !== 16'd3) begin n_fail++; $display("FAIL over_count: got %0d required 3", frames_len_err); end
      clear_mon();
      drive_frame(PRE, with_fcs(make_payload(60, 6)), -1, -1);
      n_chk++; if (commit_cnt != 1 || drop_cnt != 0 || frames_ok !== 16'd2) begin
         n_fail++; $display("FAIL over_next: got commit=%0d drop=%0d ok=%0d required 1/0/2", commit_cnt, drop_cnt, frames_ok); end
   endtask

   task automatic test_er_and_preamble();
      bq_t badpre;
      clear_mon();
      drive_frame(PRE, with_fcs(make_payload(60, 7)), 20, -1);
      n_chk++; if (rx_q.size() != 16 || drop_cnt != 1 || commit_cnt != 0) begin
         n_fail++; $display("FAIL er_drop: got bytes=%0d drop=%0d commit=%0d required 16/1/0", rx_q.size(), drop_cnt, commit_cnt); end
      n_chk++; if (drop_cyc - last_dv_cyc != 2) begin n_fail++; $display("FAIL er_drop_gap: got %0d required 2", drop_cyc - last_dv_cyc); end
      n_chk++; if (frames_ok !== 16'd2 || frames_crc_err !== 16'd1 || frames_len_err !== 16'd3) begin
         n_fail++; $display("FAIL er_count: got %0d/%0d/%0d required 2/1/3", frames_ok, frames_crc_err, frames_len_err); end
      badpre = {8'h55, 8'h54, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
      clear_mon();
      drive_frame(badpre, with_fcs(make_payload(60, 8)), -1, -1);
      n_chk++; if (rx_q.size() != 0 || start_cnt != 0 || commit_cnt != 0 || drop_cnt != 0) begin
         n_fail++; $display("FAIL badpre: got bytes=%0d start=%0d commit=%0d drop=%0d required 0", rx_q.size(), start_cnt, commit_cnt, drop_cnt); end
      n_chk++; if (frames_ok !== 16'd2 || frames_crc_err !== 16'd1 || frames_len_err !== 16'd3) begin
         n_fail++; $display("FAIL badpre_count: got %0d/%0d/%0d required 2/1/3", frames_ok, frames_crc_err, frames_len_err); end
   endtask

   task automatic test_link_down();
      clear_mon();
      drive_frame(PRE, with_fcs(make_payload(60, 9)), -1, 30);
      n_chk++; if (rx_q.size() != 26 || drop_cnt != 1 || commit_cnt != 0) begin
         n_fail++; $display("FAIL link_drop: got bytes=%0d drop=%0d commit=%0d required 26/1/0", rx_q.size(), drop_cnt, commit_cnt); end
      n_chk++; if (frames_ok !== 16'd2 || frames_crc_err !== 16'd1 || frames_len_err !== 16'd3) begin
         n_fail++; $display("FAIL link_count: got %0d/%0d/%0d required 2/1/3", frames_ok, frames_crc_err, frames_len_err); end
   endtask

   task automatic test_reset_mid();
      bq_t full = PRE;
      bq_t g = with_fcs(make_payload(60, 11));
      int bad = 0;
      full = {full, with_fcs(make_payload(60, 10))};
      clear_mon();
      for (int i = 0; i < full.size(); i++) begin
         if (i == 24) clear_mon();
         @(negedge clk);
         bus.gmii_rx_en = 1'b1; bus.gmii_rx_er = 1'b0; bus.gmii_rx_data = full[i];
         rst = (i == 20 || i == 21);
      end
      @(negedge clk);
      bus.gmii_rx_en = 1'b0;
      n_chk++; if (rx_q.size() != 0 || start_cnt != 0 || commit_cnt != 0 || drop_cnt != 0) begin
         n_fail++; $display("FAIL rstmid_quiet: got bytes=%0d start=%0d commit=%0d drop=%0d required 0", rx_q.size(), start_cnt, commit_cnt, drop_cnt); end
      clear_mon();
      drive_frame(PRE, g, -1, -1);
      for (int i = 0; i < rx_q.size() && i < 60; i++) if (rx_q[i] !== g[i]) bad++;
      n_chk++; if (rx_q.size() != 60 || bad != 0 || start_cnt != 1) begin
         n_fail++; $display("FAIL rstmid_next: got bytes=%0d wrong=%0d start=%0d required 60/0/1", rx_q.size(), bad, start_cnt); end
      n_chk++; if (commit_cnt != 1 || drop_cnt != 0) begin n_fail++; $display("FAIL rstmid_commit: got %0d/%0d required 1/0", commit_cnt, drop_cnt); end
      n_chk++; if (frames_ok !== 16'd1 || frames_crc_err !== 16'd0 || frames_len_err !== 16'd0) begin
         n_fail++; $display("FAIL rstmid_count: got %0d/%0d/%0d required 1/0/0", frames_ok, frames_crc_err, frames_len_err); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus.gmii_rx_en = 1'b0; bus.gmii_rx_er = 1'b0; bus.gmii_rx_data = 8'h00;
      for (int i = 0; i < 7; i++) PRE.push_back(8'h55);
      PRE.push_back(8'hD5);
      test_reset();
      test_good();
      test_crc_err();
      test_runt();
      test_oversize();
      test_er_and_preamble();
      test_link_down();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
